rx_word_align_ctrl: RTL

Word-alignment controller for one RX IOD lane with x4 gearing (8-bit parallel words). It searches for a known training word by issuing BITSLIP pulses to the IOD and, if needed, switching the lane to bit-reversed order. It registers the aligned word downstream, declares lock, and monitors training traffic for loss of lock. It sits between the IOD deserializer output and the lane's word-consumer logic.

---
 rtl/rx_align_pkg.sv | 21 ++
 rtl/rx_word_align_dp.sv | 29 ++
 rtl/rx_word_align_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/rx_align_pkg.sv
// Shared types and helpers for the RX word-alignment controller and its bench.
package rx_align_pkg;

  localparam int unsigned SLIP_POSITIONS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_SLIP,
    ST_LOCKED,
    ST_FAIL
  } align_state_t;

  function automatic logic [7:0] reverse8(input logic [7:0] d);
    logic [7:0] r;
    for (int unsigned i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

endpackage

// File: rtl/rx_word_align_dp.sv
// Aligned-word register: optional bit reversal, one-cycle output register, training-word compare.
module rx_word_align_dp
  import rx_align_pkg::*;
#(
  parameter logic [7:0] TRAIN_PATTERN = 8'h2C
) (
  input  logic       SCLK,
  input  logic       RESET,
  input  logic       rev_sel,
  input  logic [7:0] rx_data_in,
  input  logic       rx_data_valid,
  output logic [7:0] rx_data_out,
  output logic       rx_data_out_valid,
  output logic       match
);

  always_ff @(posedge SCLK) begin
    if (RESET) begin
      rx_data_out       <= '0;
      rx_data_out_valid <= 1'b0;
    end else begin
      rx_data_out       <= rev_sel ? reverse8(rx_data_in) : rx_data_in;
      rx_data_out_valid <= rx_data_valid;
    end
  end

  assign match = rx_data_out_valid && (rx_data_out == TRAIN_PATTERN);

endmodule

// File: rtl/rx_word_align_ctrl.sv
// Word-alignment controller for one x4 RX IOD lane: BITSLIP/bit-reverse search,
// lock declaration and loss-of-lock monitoring on training traffic.
module rx_word_align_ctrl
  import rx_align_pkg::*;
#(
  parameter logic [7:0]  TRAIN_PATTERN = 8'h2C,
  parameter int unsigned MATCH_COUNT   = 16,
  parameter int unsigned SLIP_WAIT     = 4,
  parameter int unsigned LOSS_THRESH   = 4
) (
  input  logic       SCLK,
  input  logic       RESET,
  input  logic       start,
  input  logic       train_mode,
  input  logic [7:0] rx_data_in,
  input  logic       rx_data_valid,
  output logic       bitslip,
  output logic       rev_sel,
  output logic [7:0] rx_data_out,
  output logic       rx_data_out_valid,
  output logic       locked,
  output logic       fail,
  output logic [3:0] slip_count,
  output logic       busy
);

  align_state_t state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic [7:0] match_cnt, match_nxt;
  logic [7:0] loss_cnt, loss_nxt;
  logic       bitslip_nxt, rev_nxt, locked_nxt, fail_nxt;
  logic [3:0] slip_nxt;
  logic       match;

  rx_word_align_dp #(
    .TRAIN_PATTERN(TRAIN_PATTERN)
  ) u_dp (
    .SCLK             (SCLK),
    .RESET            (RESET),
    .rev_sel          (rev_sel),
    .rx_data_in       (rx_data_in),
    .rx_data_valid    (rx_data_valid),
    .rx_data_out      (rx_data_out),
    .rx_data_out_valid(rx_data_out_valid),
    .match            (match)
  );

  assign busy = (state == ST_WAIT) || (state == ST_CHECK) || (state == ST_SLIP);

  always_ff @(posedge SCLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      match_cnt  <= '0;
      loss_cnt   <= '0;
      bitslip    <= 1'b0;
      rev_sel    <= 1'b0;
      slip_count <= '0;
      locked     <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_nxt;
      match_cnt  <= match_nxt;
      loss_cnt   <= loss_nxt;
      bitslip    <= bitslip_nxt;
      rev_sel    <= rev_nxt;
      slip_count <= slip_nxt;
      locked     <= locked_nxt;
      fail       <= fail_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    match_nxt   = match_cnt;
    loss_nxt    = loss_cnt;
    bitslip_nxt = 1'b0;
    rev_nxt     = rev_sel;
    slip_nxt    = slip_count;
    locked_nxt  = locked;
    fail_nxt    = fail;

    case (state)
      ST_WAIT: begin
        if (wait_cnt == 8'(SLIP_WAIT - 1)) begin
          wait_nxt  = '0;
          match_nxt = '0;
          state_nxt = ST_CHECK;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      ST_CHECK: begin
        if (match) begin
          if (match_cnt == 8'(MATCH_COUNT - 1)) begin
            locked_nxt = 1'b1;
            loss_nxt   = '0;
            state_nxt  = ST_LOCKED;
          end else begin
            match_nxt = match_cnt + 8'd1;
          end
        end else if (rx_data_out_valid) begin
          state_nxt = ST_SLIP;
        end
      end
      ST_SLIP: begin
        wait_nxt = '0;
        if (slip_count != 4'(SLIP_POSITIONS - 1)) begin
          bitslip_nxt = 1'b1;
          slip_nxt    = slip_count + 4'd1;
          state_nxt   = ST_WAIT;
        end else if (!rev_sel) begin
          // Eighth slip wraps the IOD back to position 0 for the reversed pass.
          bitslip_nxt = 1'b1;
          rev_nxt     = 1'b1;
          slip_nxt    = '0;
          state_nxt   = ST_WAIT;
        end else begin
          fail_nxt  = 1'b1;
          state_nxt = ST_FAIL;
        end
      end
      ST_LOCKED: begin
        if (!train_mode || match) begin
          loss_nxt = '0;
        end else if (rx_data_out_valid) begin
          if (loss_cnt == 8'(LOSS_THRESH - 1)) begin
            loss_nxt   = '0;
            locked_nxt = 1'b0;
            state_nxt  = ST_SLIP;
          end else begin
            loss_nxt = loss_cnt + 8'd1;
          end
        end
      end
      default: ;
    endcase

    // Restart is honoured from IDLE, LOCKED and FAIL; a running search ignores it.
    if (start && !busy) begin
      rev_nxt    = 1'b0;
      slip_nxt   = '0;
      locked_nxt = 1'b0;
      fail_nxt   = 1'b0;
      wait_nxt   = '0;
      loss_nxt   = '0;
      state_nxt  = ST_WAIT;
    end
  end

endmodule
